// File: rtl/turret_rom_arbiter.sv
// turret_rom_arbiter: round-robin sharing of one synchronous turret sprite ROM between
// N_REQ draw units, one read per cycle, each returned word tagged with its requester id.
module turret_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 3,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      arb_en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam logic [ID_W:0]   N_LIM   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              stage_valid_q [ROM_LAT+1];
  logic              stage_valid_d [ROM_LAT+1];
  logic [ID_W-1:0]   stage_id_q    [ROM_LAT+1];
  logic [ID_W-1:0]   stage_id_d    [ROM_LAT+1];
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic              grant_valid;
  logic [ADDR_W-1:0] addr_sel;

  // Rotating search from ptr; the wrap is explicit so non-power-of-2 N_REQ works.
  always_comb begin
    logic [ID_W:0]   cand_w;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand_w = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_w = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand_w >= N_LIM) begin
        cand_w = cand_w - N_LIM;
      end
      cand = cand_w[ID_W-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_valid = found && arb_en && reset_n;

  always_comb begin
    gnt      = '0;
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        gnt[i]   = grant_valid;
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    rom_address_d = rom_address_q;
    if (grant_valid) begin
      ptr_d         = (winner == LAST_ID) ? '0 : winner + 1'b1;
      rom_address_d = addr_sel;
    end
  end

  // The valid/id shift register lines up with rom_q so the tag meets its data word.
  always_comb begin
    stage_valid_d[0] = grant_valid;
    stage_id_d[0]    = grant_valid ? winner : stage_id_q[0];
    for (int s = 1; s <= ROM_LAT; s++) begin
      stage_valid_d[s] = stage_valid_q[s-1];
      stage_id_d[s]    = stage_id_q[s-1];
    end
    rsp_valid_d = stage_valid_q[ROM_LAT];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (stage_valid_q[ROM_LAT]) begin
      rsp_id_d   = stage_id_q[ROM_LAT];
      rsp_data_d = rom_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      rom_address_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      for (int s = 0; s <= ROM_LAT; s++) begin
        stage_valid_q[s] <= 1'b0;
        stage_id_q[s]    <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      rom_address_q <= rom_address_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      for (int s = 0; s <= ROM_LAT; s++) begin
        stage_valid_q[s] <= stage_valid_d[s];
        stage_id_q[s]    <= stage_id_d[s];
      end
    end
  end

  assign rom_address = rom_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_turret_rom_arbiter.sv
// Bench for turret_rom_arbiter: a default instance (4 requesters, ROM_LAT=1) and a
// 3-requester ROM_LAT=2 instance share stimulus; a per-cycle model plus directed literals.
module tb_turret_rom_arbiter;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        reset_n;
  logic        arb_en;
  logic [3:0]  req;
  logic [43:0] req_addr;

  logic [3:0]  gnt_a;
  logic [10:0] rom_address_a;
  logic [2:0]  rom_q_a;
  logic [2:0]  rom_pipe_a;
  logic        rsp_valid_a;
  logic [1:0]  rsp_id_a;
  logic [2:0]  rsp_data_a;

  logic [2:0]  gnt_b;
  logic [10:0] rom_address_b;
  logic [2:0]  rom_q_b;
  logic [2:0]  rom_pipe_b [2];
  logic        rsp_valid_b;
  logic [1:0]  rsp_id_b;
  logic [2:0]  rsp_data_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  turret_rom_arbiter #(.N_REQ(4), .ADDR_W(11), .DATA_W(3), .ROM_LAT(1)) dut_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .arb_en(arb_en),
    .req(req), .req_addr(req_addr), .gnt(gnt_a),
    .rom_address(rom_address_a), .rom_q(rom_q_a),
    .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_data(rsp_data_a)
  );

  turret_rom_arbiter #(.N_REQ(3), .ADDR_W(11), .DATA_W(3), .ROM_LAT(2)) dut_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .arb_en(arb_en),
    .req(req[2:0]), .req_addr(req_addr[32:0]), .gnt(gnt_b),
    .rom_address(rom_address_b), .rom_q(rom_q_b),
    .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b)
  );

  // ROM contents: word = low three address bits, returned ROM_LAT cycles after the address.
  always @(posedge vga_clk) begin
    rom_pipe_a    <= rom_address_a[2:0];
    rom_pipe_b[0] <= rom_address_b[2:0];
    rom_pipe_b[1] <= rom_pipe_b[0];
  end
  assign rom_q_a = rom_pipe_a;
  assign rom_q_b = rom_pipe_b[1];

  // Model state per instance: rotation pointer, last issued address, held response,
  // and a cycle-indexed calendar of responses that are due.
  int         m_ptr   [2];
  logic [10:0] m_addr [2];
  logic [1:0] m_id    [2];
  logic [2:0] m_data  [2];
  logic       m_sv    [2][16];
  logic [1:0] m_sid   [2][16];
  logic [2:0] m_sdata [2][16];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input int d, input int n, input int lat, input logic [3:0] rq,
                             input logic [3:0] g, input logic v, input logic [1:0] id,
                             input logic [2:0] data, input logic [10:0] ra);
    int         slot;
    int         w;
    int         due;
    logic [3:0] exp_g;
    logic       exp_v;
    string      tag;
    tag  = (d == 0) ? "A" : "B";
    slot = cyc % 16;
    if (!reset_n) begin
      m_ptr[d]  = 0;
      m_addr[d] = '0;
      m_id[d]   = '0;
      m_data[d] = '0;
      for (int s = 0; s < 16; s++) m_sv[d][s] = 1'b0;
    end
    exp_v = m_sv[d][slot];
    if (exp_v) begin
      m_id[d]   = m_sid[d][slot];
      m_data[d] = m_sdata[d][slot];
    end
    m_sv[d][slot] = 1'b0;
    w = -1;
    if (reset_n && arb_en) begin
      for (int k = 0; k < n; k++) begin
        if (w < 0 && rq[(m_ptr[d] + k) % n]) w = (m_ptr[d] + k) % n;
      end
    end
    exp_g = (w >= 0) ? 4'(1 << w) : 4'b0000;
    cmp({tag, ".gnt"}, 32'(g), 32'(exp_g));
    cmp({tag, ".rsp_valid"}, 32'(v), 32'(exp_v));
    cmp({tag, ".rsp_id"}, 32'(id), 32'(m_id[d]));
    cmp({tag, ".rsp_data"}, 32'(data), 32'(m_data[d]));
    cmp({tag, ".rom_address"}, 32'(ra), 32'(m_addr[d]));
    if (w >= 0) begin
      m_ptr[d]       = (w + 1) % n;
      m_addr[d]      = req_addr[w*11 +: 11];
      due            = (cyc + 2 + lat) % 16;
      m_sv[d][due]   = 1'b1;
      m_sid[d][due]  = 2'(w);
      m_sdata[d][due] = req_addr[w*11 +: 3];
    end
  endtask

  // Compare both instances against the model at every falling edge.
  always @(negedge vga_clk) begin
    checkOutput(0, 4, 1, req, gnt_a, rsp_valid_a, rsp_id_a, rsp_data_a, rom_address_a);
    checkOutput(1, 3, 2, {1'b0, req[2:0]}, {1'b0, gnt_b}, rsp_valid_b, rsp_id_b, rsp_data_b,
                rom_address_b);
    cyc++;
  end

  task automatic applyStimulus(input logic [3:0] r, input logic en, input int ncyc);
    req    = r;
    arb_en = en;
    repeat (ncyc) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic nextCycle();
    @(posedge vga_clk);
    #1;
  endtask

  // Directed sequences with hand-computed expectations.
  initial begin
    logic [3:0] rr_gnt_a [5];
    logic [2:0] rr_gnt_b [5];
    logic [1:0] rr_id_a  [6];
    logic [1:0] rr_id_b  [5];
    logic [3:0] skip_req [5];
    logic [3:0] skip_gnt [5];
    logic [3:0] drop_gnt [3];
    int         pulses_a;
    int         pulses_b;
    rr_gnt_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_gnt_b = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rr_id_a  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_id_b  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    skip_req = '{4'b0011, 4'b0011, 4'b0011, 4'b1011, 4'b1011};
    skip_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b1000};
    drop_gnt = '{4'b0001, 4'b0010, 4'b0100};

    reset_n  = 1'b1;
    arb_en   = 1'b0;
    req      = 4'b0000;
    req_addr = {11'h7FE, 11'h0B3, 11'h2A5, 11'h101};
    #1 reset_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1 reset_n = 1'b1;

    $display("[TB] reset asserted mid-stream");
    applyStimulus(4'b1111, 1'b1, 5);
    cmp("pre_reset.rsp_valid_a", 32'(rsp_valid_a), 32'd1);
    reset_n = 1'b0;
    #1;
    cmp("async_reset.gnt_a", 32'(gnt_a), 32'd0);
    cmp("async_reset.rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    cmp("async_reset.gnt_b", 32'(gnt_b), 32'd0);
    cmp("async_reset.rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;

    $display("[TB] round-robin with all requesting");
    for (int k = 0; k < 9; k++) begin
      @(negedge vga_clk);
      if (k <= 4) begin
        cmp("rr.gnt_a", 32'(gnt_a), 32'(rr_gnt_a[k]));
        cmp("rr.gnt_b", 32'(gnt_b), 32'(rr_gnt_b[k]));
      end
      if (k == 3) cmp("rr.rsp_valid_b_not_early", 32'(rsp_valid_b), 32'd0);
      if (k == 3) cmp("rr.rsp_data_a", 32'(rsp_data_a), 32'd1);
      if (k >= 3) begin
        cmp("rr.rsp_valid_a", 32'(rsp_valid_a), 32'd1);
        cmp("rr.rsp_id_a", 32'(rsp_id_a), 32'(rr_id_a[k-3]));
      end
      if (k >= 4) begin
        cmp("rr.rsp_valid_b", 32'(rsp_valid_b), 32'd1);
        cmp("rr.rsp_id_b", 32'(rsp_id_b), 32'(rr_id_b[k-4]));
      end
      nextCycle();
    end
    applyStimulus(4'b0000, 1'b1, 6);

    $display("[TB] single read data path");
    applyStimulus(4'b0010, 1'b1, 0);
    @(negedge vga_clk);
    cmp("data.gnt_a", 32'(gnt_a), 32'b0010);
    nextCycle();
    req = 4'b0000;
    nextCycle();
    nextCycle();
    @(negedge vga_clk);
    cmp("data.rsp_valid_a", 32'(rsp_valid_a), 32'd1);
    cmp("data.rsp_id_a", 32'(rsp_id_a), 32'd1);
    cmp("data.rsp_data_a", 32'(rsp_data_a), 32'd5);
    cmp("data.rsp_valid_b_lat4_not_yet", 32'(rsp_valid_b), 32'd0);
    nextCycle();
    @(negedge vga_clk);
    cmp("data.rsp_valid_b", 32'(rsp_valid_b), 32'd1);
    cmp("data.rsp_id_b", 32'(rsp_id_b), 32'd1);
    cmp("data.rsp_data_b", 32'(rsp_data_b), 32'd5);
    cmp("data.rsp_valid_a_pulse", 32'(rsp_valid_a), 32'd0);
    cmp("data.rsp_data_a_held", 32'(rsp_data_a), 32'd5);
    nextCycle();

    $display("[TB] skip and late joiner");
    for (int k = 0; k < 5; k++) begin
      req = skip_req[k];
      @(negedge vga_clk);
      cmp("skip.gnt_a", 32'(gnt_a), 32'(skip_gnt[k]));
      nextCycle();
    end
    applyStimulus(4'b0000, 1'b1, 6);

    $display("[TB] arb_en drop with reads in flight");
    pulses_a = 0;
    pulses_b = 0;
    applyStimulus(4'b1111, 1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge vga_clk);
      if (k < 3) cmp("drop.gnt_a", 32'(gnt_a), 32'(drop_gnt[k]));
      if (k == 3) cmp("drop.gnt_a_stopped", 32'(gnt_a), 32'd0);
      if (k == 3) cmp("drop.gnt_b_stopped", 32'(gnt_b), 32'd0);
      if (rsp_valid_a) pulses_a++;
      if (rsp_valid_b) pulses_b++;
      nextCycle();
      if (k == 2) arb_en = 1'b0;
    end
    cmp("drop.pulses_a", 32'(pulses_a), 32'd3);
    cmp("drop.pulses_b", 32'(pulses_b), 32'd3);
    applyStimulus(4'b0000, 1'b1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
